// File: rtl/ml_sched_pkg.sv
// Shared types and constants for the ML inference scheduler: feature/tag widths,
// anomaly class codes and the routed-response record.
package ml_sched_pkg;
  localparam int FEAT_W      = 128;
  localparam int NUM_CLASSES = 6;
  localparam int CLS_W       = $clog2(NUM_CLASSES);
  localparam int CONF_W      = 8;
  localparam int ENG_LATENCY = 4;
  localparam int TAG_W       = 3;
  localparam int TAG_DEPTH   = 8;
  localparam int CNT_W       = 4;

  typedef enum logic [CLS_W-1:0] {
    CLS_NORMAL          = 3'd0,
    CLS_PRICE_SPIKE     = 3'd1,
    CLS_VOLUME_SURGE    = 3'd2,
    CLS_FLASH_CRASH     = 3'd3,
    CLS_ORDER_IMBALANCE = 3'd4,
    CLS_QUOTE_STUFFING  = 3'd5
  } cls_e;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    tag_t              id;
    logic [CLS_W-1:0]  cls;
    logic [CONF_W-1:0] conf;
  } rsp_t;

  // Modulo for an index known to be below 2*n.
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction
endpackage

// File: rtl/ml_infer_scheduler_if.sv
// Requester, engine and response buses of the inference scheduler.
// master = requesters + engine side, slave = scheduler.
interface ml_infer_scheduler_if #(parameter int NUM_REQ = 4);
  import ml_sched_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][FEAT_W-1:0] req_features;
  logic [NUM_REQ-1:0]             req_ready;
  logic [FEAT_W-1:0]              eng_features;
  logic                           eng_feature_valid;
  logic [CLS_W-1:0]               eng_class;
  logic [CONF_W-1:0]              eng_confidence;
  logic                           eng_valid;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [CLS_W-1:0]               rsp_class;
  logic [CONF_W-1:0]              rsp_confidence;
  logic [TAG_W-1:0]               rsp_id;
  logic                           crit_alert;

  modport master (
    output req_valid, req_features, eng_class, eng_confidence, eng_valid,
    input  req_ready, eng_features, eng_feature_valid,
           rsp_valid, rsp_class, rsp_confidence, rsp_id, crit_alert
  );

  modport slave (
    input  req_valid, req_features, eng_class, eng_confidence, eng_valid,
    output req_ready, eng_features, eng_feature_valid,
           rsp_valid, rsp_class, rsp_confidence, rsp_id, crit_alert
  );
endinterface

// File: rtl/ml_tag_fifo.sv
// 8-entry FIFO of requester ids, one entry per vector in flight through the engine.
// Simultaneous push and pop on a non-empty queue keeps the count unchanged.
module ml_tag_fifo
  import ml_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  tag_t             din,
  input  logic             pop,
  output tag_t             dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  tag_t             mem [TAG_DEPTH];
  logic [TAG_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CNT_W'(TAG_DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout  = mem[rptr];
  assign empty = (cnt == '0);
  assign count = cnt;
endmodule

// File: rtl/ml_infer_scheduler.sv
// Round-robin scheduler sharing one pipelined inference engine between NUM_REQ
// feature producers; tags issues in order and routes each result back to its owner.
module ml_infer_scheduler
  import ml_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LATENCY      = ENG_LATENCY,
  parameter int MAX_INFLIGHT = 8,
  parameter int MIN_GAP      = 0,
  parameter int CRIT_CLASS   = int'(CLS_FLASH_CRASH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  ml_infer_scheduler_if.slave  bus,
  output logic [CNT_W-1:0]     inflight,
  output logic                 busy,
  output logic                 err_orphan
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(MIN_GAP + 1) + 1;
  localparam int DRN_W = $clog2(LATENCY + 1) + 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [GAP_W-1:0]   gap_cnt;
  logic [DRN_W-1:0]   drain_cnt;
  logic               grant_ok, found, xfer, pop, drained;
  logic [PTR_W-1:0]   pick_id;
  logic [NUM_REQ-1:0] grant;
  tag_t               tag_head;
  logic               tag_empty;
  rsp_t               rsp_q;
  logic               rsp_vld_q;

  assign drained  = (drain_cnt == '0);
  assign grant_ok = cfg_enable && (gap_cnt == '0) &&
                    (inflight < CNT_W'(MAX_INFLIGHT)) && drained;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant   = '0;
    pick_id = '0;
    found   = 1'b0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!found && bus.req_valid[wrap_idx(int'(rr_ptr) + o, NUM_REQ)]) begin
        found   = 1'b1;
        pick_id = PTR_W'(wrap_idx(int'(rr_ptr) + o, NUM_REQ));
      end
    end
    if (grant_ok && found) grant[pick_id] = 1'b1;
  end

  assign bus.req_ready = grant;
  assign xfer          = grant_ok && found;
  // Results showing up during the post-reset drain belong to pre-reset issues.
  assign pop           = bus.eng_valid && drained && !tag_empty;

  ml_tag_fifo u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer),
    .din   (TAG_W'(pick_id)),
    .pop   (pop),
    .dout  (tag_head),
    .empty (tag_empty),
    .count (inflight)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr                <= '0;
      gap_cnt               <= '0;
      drain_cnt             <= DRN_W'(LATENCY);
      bus.eng_features      <= '0;
      bus.eng_feature_valid <= 1'b0;
      rsp_q                 <= '0;
      rsp_vld_q             <= 1'b0;
      err_orphan            <= 1'b0;
    end else begin
      bus.eng_feature_valid <= xfer;
      if (xfer) begin
        bus.eng_features <= bus.req_features[pick_id];
        rr_ptr           <= PTR_W'(wrap_idx(int'(pick_id) + 1, NUM_REQ));
        gap_cnt          <= GAP_W'(MIN_GAP);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      if (!drained) drain_cnt <= drain_cnt - 1'b1;

      rsp_vld_q <= pop;
      if (pop) rsp_q <= '{id: tag_head, cls: bus.eng_class, conf: bus.eng_confidence};
      if (bus.eng_valid && drained && tag_empty) err_orphan <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign bus.rsp_valid[i] = rsp_vld_q && (rsp_q.id == TAG_W'(i));
  end

  assign bus.rsp_class      = rsp_q.cls;
  assign bus.rsp_confidence = rsp_q.conf;
  assign bus.rsp_id         = rsp_q.id;
  assign bus.crit_alert     = rsp_vld_q && (rsp_q.cls == CLS_W'(CRIT_CLASS));
  assign busy               = (inflight != '0);
endmodule

// File: tb/tb_ml_infer_scheduler.sv
// Bench for ml_infer_scheduler: three instances (default, MAX_INFLIGHT=2, MIN_GAP=3),
// a fixed-latency engine stub per instance and an in-order response scoreboard.
module tb_ml_infer_scheduler;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int NI   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                       cfg_en [NI];
  logic [NREQ-1:0]            rv     [NI];
  logic [NREQ-1:0][127:0]     rf     [NI];
  logic                       inj    [NI];
  logic                       fixed;
  logic [2:0]                 fx_cls;
  logic [7:0]                 fx_conf;

  logic [NREQ-1:0] rdy [NI];
  logic [NREQ-1:0] rspv [NI];
  logic            efv [NI];
  logic [127:0]    ef [NI];
  logic [2:0]      rcls [NI];
  logic [2:0]      rid [NI];
  logic [7:0]      rconf [NI];
  logic            crit [NI];
  logic [3:0]      infl [NI];
  logic            busy [NI];
  logic            orph [NI];

  logic [LAT-1:0]        spipe [NI] = '{default: '0};
  logic [LAT-1:0][10:0]  sdata [NI] = '{default: '0};

  // Engine behaviour: fixed result, or class = byte0[2:0], confidence = byte1.
  function automatic logic [10:0] eng_model(input logic [127:0] f);
    return fixed ? {fx_cls, fx_conf} : {f[2:0], f[15:8]};
  endfunction

  always @(posedge clk)
    for (int k = 0; k < NI; k++) begin
      spipe[k] <= {spipe[k][LAT-2:0], efv[k]};
      sdata[k] <= {sdata[k][LAT-2:0], eng_model(ef[k])};
    end

  for (genvar k = 0; k < NI; k++) begin : g
    ml_infer_scheduler_if #(.NUM_REQ(NREQ)) bus ();
    assign bus.req_valid      = rv[k];
    assign bus.req_features   = rf[k];
    assign bus.eng_valid      = spipe[k][LAT-1] | inj[k];
    assign bus.eng_class      = sdata[k][LAT-1][10:8];
    assign bus.eng_confidence = sdata[k][LAT-1][7:0];
    assign rdy[k]   = bus.req_ready;
    assign efv[k]   = bus.eng_feature_valid;
    assign ef[k]    = bus.eng_features;
    assign rspv[k]  = bus.rsp_valid;
    assign rcls[k]  = bus.rsp_class;
    assign rconf[k] = bus.rsp_confidence;
    assign rid[k]   = bus.rsp_id;
    assign crit[k]  = bus.crit_alert;

    ml_infer_scheduler #(
      .NUM_REQ(NREQ), .LATENCY(LAT), .MAX_INFLIGHT(k == 1 ? 2 : 8),
      .MIN_GAP(k == 2 ? 3 : 0), .CRIT_CLASS(3)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_enable (cfg_en[k]),
      .bus        (bus),
      .inflight   (infl[k]),
      .busy       (busy[k]),
      .err_orphan (orph[k])
    );
  end

  typedef struct {
    int         k;
    logic [2:0] id;
    logic [2:0] cls;
    logic [7:0] conf;
    int         t;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  // Scoreboard: expectation pushed on each transfer, checked when the response appears.
  always @(negedge clk) begin
    if (rst) sbq.delete();
    else begin
      for (int k = 0; k < NI; k++) begin
        if (rspv[k] != '0) begin
          total++;
          if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_rsp inst=%0d rsp_valid=%b required none", k, rspv[k]);
          end else begin
            e = sbq.pop_front();
            if (e.k != k || rspv[k] !== 4'(1 << e.id) || rid[k] !== e.id || rcls[k] !== e.cls ||
                rconf[k] !== e.conf || crit[k] !== (e.cls == 3'd3) || (cyc - e.t) != LAT + 2) begin
              bad++;
              $display("FAIL sb_rsp got inst=%0d v=%b id=%0d cls=%0d conf=%h crit=%b lat=%0d required inst=%0d id=%0d cls=%0d conf=%h crit=%b lat=%0d",
                       k, rspv[k], rid[k], rcls[k], rconf[k], crit[k], cyc - e.t,
                       e.k, e.id, e.cls, e.conf, e.cls == 3'd3, LAT + 2);
            end
          end
        end else if (crit[k] !== 1'b0) begin
          total++; bad++;
          $display("FAIL crit_without_rsp inst=%0d crit=%b required 0", k, crit[k]);
        end
      end
      for (int k = 0; k < NI; k++)
        for (int i = 0; i < NREQ; i++)
          if (rv[k][i] && rdy[k][i])
            sbq.push_back('{k: k, id: 3'(i), cls: eng_model(rf[k][i])[10:8],
                            conf: eng_model(rf[k][i])[7:0], t: cyc});
    end
  end

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    rv[0] = 4'hF;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (rdy[0] !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b required=0000", rdy[0]); end
    total++;
    if ({efv[0], rspv[0], crit[0], busy[0], orph[0], infl[0]} !== '0 || ef[0] !== '0) begin
      bad++; $display("FAIL reset_outputs got efv=%b rspv=%b crit=%b busy=%b orph=%b infl=%0d ef=%h required all 0",
                      efv[0], rspv[0], crit[0], busy[0], orph[0], infl[0], ef[0]);
    end
    total++;
    if ({rid[0], rcls[0], rconf[0]} !== '0) begin
      bad++; $display("FAIL reset_rsp_fields got id=%0d cls=%0d conf=%h required 0", rid[0], rcls[0], rconf[0]);
    end
    rv[0] = '0;
    #1 rst = 1'b0;
  endtask

  task automatic test_single;
    logic [127:0] f;
    f = 128'h0F0E0D0C0B0A09080706050403020100;
    rf[0][0] = f; rv[0] = 4'b0001; fixed = 1'b1; fx_cls = 3'd2; fx_conf = 8'h40;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if (rdy[0] !== (c == 4 ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL drain_ready cycle=%0d got=%b required=%b", c, rdy[0], (c == 4 ? 4'b0001 : 4'b0000));
      end
    end
    @(posedge clk); #1 rv[0] = '0;
    @(negedge clk);
    total++;
    if (efv[0] !== 1'b1 || ef[0] !== f) begin bad++; $display("FAIL issue got efv=%b ef=%h required 1 %h", efv[0], ef[0], f); end
    total++;
    if (infl[0] !== 4'd1 || busy[0] !== 1'b1) begin bad++; $display("FAIL issue_inflight got=%0d busy=%b required 1 1", infl[0], busy[0]); end
    repeat (4) @(negedge clk);
    total++;
    if (rspv[0] !== 4'b0) begin bad++; $display("FAIL rsp_early got=%b required=0000", rspv[0]); end
    @(negedge clk);
    total++;
    if (rspv[0] !== 4'b0001 || rcls[0] !== 3'd2 || rconf[0] !== 8'h40 || rid[0] !== 3'd0) begin
      bad++; $display("FAIL single_rsp got v=%b cls=%0d conf=%h id=%0d required 0001 2 40 0", rspv[0], rcls[0], rconf[0], rid[0]);
    end
    @(negedge clk);
    total++;
    if (rspv[0] !== 4'b0 || rcls[0] !== 3'd2 || rconf[0] !== 8'h40 || busy[0] !== 1'b0 || infl[0] !== 4'd0) begin
      bad++; $display("FAIL rsp_hold got v=%b cls=%0d conf=%h busy=%b infl=%0d required 0000 2 40 0 0",
                      rspv[0], rcls[0], rconf[0], busy[0], infl[0]);
    end
    fixed = 1'b0;
  endtask

  task automatic test_back_to_back;
    int w;
    for (int i = 0; i < NREQ; i++) begin
      rf[0][i] = {$urandom, $urandom, $urandom, 16'h0, 8'(8'h10 + i), 8'(i)};
    end
    rv[0] = 4'hF;
    do_reset();
    for (int n = 0; n <= 16; n++) begin
      @(negedge clk);
      if (n >= 4) begin
        total++;
        if (rdy[0] !== 4'(1 << ((n - 4) % 4))) begin
          bad++; $display("FAIL rr_grant cycle=%0d got=%b required=%b", n, rdy[0], 4'(1 << ((n - 4) % 4)));
        end
        total++;
        if (infl[0] !== 4'((n - 4 < 5) ? n - 4 : 5)) begin
          bad++; $display("FAIL rr_inflight cycle=%0d got=%0d required=%0d", n, infl[0], (n - 4 < 5) ? n - 4 : 5);
        end
      end
    end
    @(posedge clk); #1 rv[0] = '0;
    w = 0;
    while (busy[0] === 1'b1 && w < 30) begin @(negedge clk); w++; end
    @(negedge clk);
    total++;
    if (busy[0] !== 1'b0 || sbq.size() != 0) begin
      bad++; $display("FAIL rr_drain got busy=%b pending=%0d required 0 0", busy[0], sbq.size());
    end
  endtask

  task automatic test_inflight_cap;
    logic [3:0] tab [17];
    int w;
    tab = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,
            4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    for (int i = 0; i < NREQ; i++) rf[1][i] = {$urandom, $urandom, $urandom, 16'h0, 8'(8'hA0 + i), 8'(i)};
    rv[1] = 4'hF;
    do_reset();
    for (int n = 0; n <= 16; n++) begin
      @(negedge clk);
      total++;
      if (rdy[1] !== tab[n]) begin bad++; $display("FAIL cap_grant cycle=%0d got=%b required=%b", n, rdy[1], tab[n]); end
      if (n == 10) begin
        total++;
        if (rspv[1] !== 4'b0001) begin bad++; $display("FAIL cap_rsp_with_grant got=%b required=0001", rspv[1]); end
      end
    end
    @(posedge clk); #1 rv[1] = '0;
    w = 0;
    while (busy[1] === 1'b1 && w < 40) begin @(negedge clk); w++; end
    @(negedge clk);
    total++;
    if (busy[1] !== 1'b0 || sbq.size() != 0) begin
      bad++; $display("FAIL cap_drain got busy=%b pending=%0d required 0 0", busy[1], sbq.size());
    end
  endtask

  task automatic test_min_gap;
    int w;
    logic exp_v;
    for (int i = 0; i < NREQ; i++) rf[2][i] = {$urandom, $urandom, $urandom, 16'h0, 8'(8'h30 + i), 8'(i)};
    rv[2] = 4'b0011;
    do_reset();
    for (int n = 0; n <= 18; n++) begin
      @(negedge clk);
      exp_v = (n >= 5) && ((n - 5) % 4 == 0);
      total++;
      if (efv[2] !== exp_v) begin bad++; $display("FAIL gap_pulse cycle=%0d got=%b required=%b", n, efv[2], exp_v); end
      if (exp_v) begin
        total++;
        if (ef[2][7:0] !== 8'(((n - 5) / 4) % 2)) begin
          bad++; $display("FAIL gap_id cycle=%0d got=%0d required=%0d", n, ef[2][7:0], ((n - 5) / 4) % 2);
        end
      end
    end
    rv[2] = '0;
    w = 0;
    while (busy[2] === 1'b1 && w < 30) begin @(negedge clk); w++; end
    @(negedge clk);
    total++;
    if (busy[2] !== 1'b0 || sbq.size() != 0) begin
      bad++; $display("FAIL gap_drain got busy=%b pending=%0d required 0 0", busy[2], sbq.size());
    end
  endtask

  task automatic test_crit;
    rf[0][0] = {112'h1234, 8'h77, 8'd3};
    rf[0][1] = {112'h5678, 8'h55, 8'd5};
    rv[0] = 4'b0011;
    do_reset();
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (n >= 9) begin
        total++;
        if (crit[0] !== (n == 10)) begin bad++; $display("FAIL crit_pulse cycle=%0d got=%b required=%b", n, crit[0], n == 10); end
      end
      if (n == 11) begin
        total++;
        if (rspv[0] !== 4'b0010 || rcls[0] !== 3'd5) begin
          bad++; $display("FAIL crit_second got v=%b cls=%0d required 0010 5", rspv[0], rcls[0]);
        end
      end
      if (n == 5) begin @(posedge clk); #1 rv[0] = '0; end
    end
  endtask

  task automatic test_cfg_disable;
    for (int i = 0; i < NREQ; i++) rf[0][i] = {$urandom, $urandom, $urandom, 16'h0, 8'(8'h50 + i), 8'(i)};
    rv[0] = 4'hF;
    do_reset();
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (n >= 6) begin
        total++;
        if (rdy[0] !== 4'b0) begin bad++; $display("FAIL dis_ready cycle=%0d got=%b required=0000", n, rdy[0]); end
      end
      if (n == 10 || n == 11) begin
        total++;
        if (busy[0] !== (n == 10)) begin bad++; $display("FAIL dis_busy cycle=%0d got=%b required=%b", n, busy[0], n == 10); end
      end
      if (n == 5) begin @(posedge clk); #1 cfg_en[0] = 1'b0; end
    end
    rv[0] = '0;
    cfg_en[0] = 1'b1;
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < NREQ; i++) rf[0][i] = {$urandom, $urandom, $urandom, 16'h0, 8'(8'h60 + i), 8'(i)};
    rv[0] = 4'hF;
    do_reset();
    repeat (7) @(negedge clk);
    @(posedge clk); #1 rv[0] = '0;
    do_reset();
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      total++;
      if (rspv[0] !== 4'b0 || orph[0] !== 1'b0 || busy[0] !== 1'b0) begin
        bad++; $display("FAIL midrst_flush cycle=%0d got v=%b orph=%b busy=%b required 0000 0 0", n, rspv[0], orph[0], busy[0]);
      end
    end
  endtask

  task automatic test_orphan;
    rv[0] = '0;
    do_reset();
    for (int n = 0; n <= 14; n++) begin
      @(negedge clk);
      if (n >= 3) begin
        total++;
        if (orph[0] !== (n >= 11) || rspv[0] !== 4'b0) begin
          bad++; $display("FAIL orphan cycle=%0d got orph=%b v=%b required %b 0000", n, orph[0], rspv[0], n >= 11);
        end
      end
      if (n == 1 || n == 9)  begin @(posedge clk); #1 inj[0] = 1'b1; end
      if (n == 2 || n == 10) begin @(posedge clk); #1 inj[0] = 1'b0; end
    end
    do_reset();
    @(negedge clk);
    total++;
    if (orph[0] !== 1'b0) begin bad++; $display("FAIL orphan_clear got=%b required=0", orph[0]); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    fixed = 1'b0; fx_cls = '0; fx_conf = '0;
    for (int k = 0; k < NI; k++) begin
      cfg_en[k] = 1'b1; rv[k] = '0; rf[k] = '0; inj[k] = 1'b0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_inflight_cap();
    test_min_gap();
    test_crit();
    test_cfg_disable();
    test_mid_reset();
    test_orphan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
